// File: rtl/lsu_req_stage_pkg.sv
// Shared types and helpers for the data-memory request stage and its alignment logic.
package lsu_req_stage_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned ADDR_W_DEFAULT  = 32;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } lsu_state_e;

  // Natural alignment: halves on even bytes, words on word boundaries, size 11 never.
  function automatic logic is_aligned(mem_size_e size, logic [1:0] off);
    case (size)
      BYTE:    return 1'b1;
      HALF:    return ~off[0];
      WORD:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Byte-lane enables; loads and stores share the same pattern.
  function automatic logic [3:0] be_for(mem_size_e size, logic [1:0] off);
    case (size)
      BYTE:    return 4'b0001 << off;
      HALF:    return 4'b0011 << off;
      WORD:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the low bits across all lanes so the memory picks the enabled ones.
  function automatic logic [31:0] replicate_wdata(mem_size_e size, logic [31:0] data);
    case (size)
      BYTE:    return {4{data[7:0]}};
      HALF:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_req_stage_if.sv
// Data-memory bus with req/gnt/rvalid handshake; master is the request stage.
interface lsu_req_stage_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/lsu_req_stage_align.sv
// Combinational alignment check, byte-enable and store-data lane generation.
module lsu_req_stage_align
  import lsu_req_stage_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic        aligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);
  assign aligned_o = is_aligned(size_i, off_i);
  assign be_o      = be_for(size_i, off_i);
  assign wdata_o   = replicate_wdata(size_i, data_i);
endmodule

// File: rtl/lsu_req_stage.sv
// Data-memory request issuer: registers the bus request, stalls until the response
// returns, drains squashed responses and flags misaligned accesses and bus timeouts.
module lsu_req_stage
  import lsu_req_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  input  logic              flush_i,
  lsu_req_stage_if.master   dmem,
  output logic              stall_o,
  output logic [1:0]        byte_offset_o,
  output logic              misaligned_o,
  output logic              bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        aligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic        mem_op, start, misaligned, timeout_hit;

  lsu_req_stage_align u_align (
    .size_i   (mem_size_e'(mem_size_i)),
    .off_i    (addr_i[1:0]),
    .data_i   (store_data_i),
    .aligned_o(aligned),
    .be_o     (be_calc),
    .wdata_o  (wdata_calc)
  );

  assign mem_op      = valid_i & (mem_read_i | mem_write_i);
  assign start       = mem_op & aligned & ~flush_i;
  assign misaligned  = mem_op & ~aligned & ~flush_i;
  // Counter starts at 0 on entry to WAIT/DRAIN, so the last allowed cycle sees TIMEOUT-1.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // State and registered outputs; reset abandons any transaction immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant beats flush in REQ; response beats timeout beats flush in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = REQ;
      REQ: begin
        if (dmem.gnt)    state_d = flush_i ? DRAIN : WAIT;
        else if (flush_i) state_d = IDLE;
      end
      WAIT: begin
        if (dmem.rvalid)      state_d = IDLE;
        else if (timeout_hit) state_d = IDLE;
        else if (flush_i)     state_d = DRAIN;
      end
      DRAIN: if (dmem.rvalid || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request/payload capture, flag pulses, timeout counter and stall.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = start;
        mis_d   = misaligned;
        if (start) begin
          req_d   = 1'b1;
          we_d    = mem_write_i;
          be_d    = be_calc;
          addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
          wdata_d = wdata_calc;
          off_d   = addr_i[1:0];
        end
      end
      REQ: begin
        stall_o = 1'b1;
        cnt_d   = '0;
        if (dmem.gnt || flush_i) req_d = 1'b0;
      end
      WAIT: begin
        stall_o = ~dmem.rvalid;
        err_d   = ~dmem.rvalid & timeout_hit;
        if (flush_i && !dmem.rvalid && !timeout_hit) cnt_d = '0;
        else if (cnt_q != '1)                        cnt_d = cnt_q + 1'b1;
      end
      DRAIN: begin
        stall_o = mem_op;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign dmem.req      = req_q;
  assign dmem.we       = we_q;
  assign dmem.be       = be_q;
  assign dmem.addr     = addr_q;
  assign dmem.wdata    = wdata_q;
  assign byte_offset_o = off_q;
  assign misaligned_o  = mis_q;
  assign bus_err_o     = err_q;

endmodule

// File: doc/lsu_req_stage.md
Name: lsu_req_stage

Overview:
- Data-memory request issuer that sits directly upstream of the memory slice stage, alongside execute.
- Takes the executing load/store and aligns store data and byte enables. It drives the dmem bus with a req/gnt/rvalid handshake and stalls the pipeline until the response returns.
- The memory slice stage samples dmem rdata in the cycle stall_o drops and uses byte_offset_o for extraction.
- Detects misaligned/illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT/DRAIN before a bus error; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- valid_i  in  1  execute-stage instruction valid
- mem_read_i  in  1  instruction is a load
- mem_write_i  in  1  instruction is a store
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- addr_i  in  ADDR_W  effective byte address
- store_data_i  in  32  unaligned store data (value in low bits)
- flush_i  in  1  squash the in-flight access
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  write enable
- dmem_be_o  out  4  byte enables
- dmem_addr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response valid (loads and stores)
- stall_o  out  1  hold upstream and memory stage
- byte_offset_o  out  2  addr[1:0] of the outstanding or current access
- misaligned_o  out  1  one-cycle misaligned/illegal-size flag
- bus_err_o  out  1  one-cycle timeout flag

Behaviour:
- Reset (async assert, sync deassert via flops):
  - state=IDLE.
  - All dmem_* outputs 0.
  - byte_offset_o=0, misaligned_o=0, bus_err_o=0, timeout counter=0.
- start = valid_i & (mem_read_i | mem_write_i) & aligned & !flush_i.
  - aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=0; size 11 is never aligned.
- FSM IDLE/REQ/WAIT/DRAIN. All dmem_* outputs are registered.
- IDLE:
  - On start: latch addr, be, wdata, we, offset; set dmem_req_o=1 next cycle; go to REQ.
  - On misaligned access with valid and !flush: misaligned_o=1 for that cycle (registered, appears next cycle), no request, no stall.
- REQ: hold dmem_req_o and payload stable until dmem_gnt_i.
  - gnt=1: clear req next cycle, go to WAIT.
  - gnt=0 & flush_i: clear req, go to IDLE.
  - gnt=1 & flush_i: go to DRAIN (grant wins).
- WAIT:
  - rvalid: go to IDLE.
  - flush_i & !rvalid: go to DRAIN.
  - Counter reaches TIMEOUT_CYCLES: bus_err_o pulse, go to IDLE.
- DRAIN: discard the response; on rvalid or timeout go to IDLE. No bus_err_o in DRAIN.
- stall_o (combinational), asserted when any of:
  - IDLE & start;
  - REQ;
  - WAIT & !dmem_rvalid_i;
  - DRAIN & valid_i & (mem_read_i | mem_write_i) (a new access waits for the drain; non-memory instructions flow).
- Latency: best case is 3 cycles from start to rvalid-cycle release (IDLE, REQ with gnt, WAIT with rvalid).
- dmem_be_o: byte = 0001<<off; half = 0011<<off; word = 1111. Loads use the same pattern.
- dmem_wdata_o: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- dmem_we_o = mem_write_i latched.
- Timeout counter: clears on entry to WAIT/DRAIN, saturates, never wraps.
- Simultaneous mem_read_i & mem_write_i: treated as a store.
- A reset mid-transaction abandons it immediately. A response arriving later in IDLE is ignored.
- An rvalid seen in IDLE or REQ is ignored.

Decomposition:
- Shared package:
  - mem_size_e (BYTE/HALF/WORD/ILLEGAL);
  - lsu_state_e;
  - be_for(size, off) and replicate_wdata(size, data) functions;
  - TIMEOUT default.
- Optional sub-module: lsu_align (combinational aligned/be/wdata generation), reusable by the memory slice stage checks.

Test Plan:
- Store byte: addr=0x1003, d=0x000000AB, gnt same cycle, rvalid 1 cycle later -> req for 1 cycle, addr 0x1000, be=1000, wdata=0xABABABAB, we=1; stall high 2 cycles then low.
- Load half: addr=0x2002, gnt after 2 wait cycles, rvalid after 3 -> req held stable 3 cycles, be=1100, byte_offset_o=2; stall released exactly on the rvalid cycle.
- Misaligned word at 0x2001 and size=11 at 0x0 -> misaligned_o pulses, dmem_req_o stays 0, stall_o stays 0.
- Flush in WAIT then rvalid 2 cycles later while the next load is presented -> DRAIN; new load stalled until rvalid, then issued with correct addr; drained data not consumed.
- TIMEOUT_CYCLES=4, no rvalid -> bus_err_o one pulse 4 cycles after grant; state IDLE; stall low.
- rst_ni asserted in REQ -> all outputs 0 asynchronously; a late rvalid after reset produces no stall and no error.
